// File: rtl/bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_logic_unit
// Brief    : Pipelined WIDTH-bit bitwise logic unit. It has eight logic
//            functions, an accumulator for multi-beat reductions,
//            valid/ready handshaking on both sides, and registered
//            zero/all-ones/parity flags.
// Revision : 1.0 - initial release
// ============================================================================
module bitwise_logic_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [2:0]       op,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_ones,
  output logic             flag_parity
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ANDN = 3'b110;

  localparam logic [1:0] MODE_ACC  = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b10;

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             flag_zero_q, flag_zero_d;
  logic             flag_ones_q, flag_ones_d;
  logic             flag_parity_q, flag_parity_d;

  logic             accept;
  logic [WIDTH-1:0] operand_x;
  logic [WIDTH-1:0] logic_r;

  // The output register frees up in the same cycle that it is consumed. No skid buffer is used.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Select the second operand and evaluate the selected bitwise function
  always_comb begin
    operand_x = (mode == MODE_ACC) ? acc_q : data_operandB;
    logic_r   = data_operandA;
    case (op)
      OP_AND:  logic_r = data_operandA & operand_x;
      OP_OR:   logic_r = data_operandA | operand_x;
      OP_XOR:  logic_r = data_operandA ^ operand_x;
      OP_NOR:  logic_r = ~(data_operandA | operand_x);
      OP_NAND: logic_r = ~(data_operandA & operand_x);
      OP_XNOR: logic_r = ~(data_operandA ^ operand_x);
      OP_ANDN: logic_r = data_operandA & ~operand_x;
      default: logic_r = data_operandA;
    endcase
  end

  // Next-state for the result register, flags, valid and accumulator
  always_comb begin
    result_d      = result_q;
    acc_d         = acc_q;
    out_valid_d   = out_valid_q;
    flag_zero_d   = flag_zero_q;
    flag_ones_d   = flag_ones_q;
    flag_parity_d = flag_parity_q;
    if (accept) begin
      result_d      = logic_r;
      out_valid_d   = 1'b1;
      flag_zero_d   = ~|logic_r;
      flag_ones_d   = &logic_r;
      flag_parity_d = ^logic_r;
      // Mode 11 is treated as 00: acc is left untouched
      if (mode == MODE_ACC || mode == MODE_LOAD) begin
        acc_d = logic_r;
      end
    end else if (out_ready) begin
      // Consumed with no replacement. Result and flags keep their last values.
      out_valid_d = 1'b0;
    end
  end

  // State registers. Reset discards any pending beat.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      result_q      <= '0;
      acc_q         <= '0;
      out_valid_q   <= 1'b0;
      flag_zero_q   <= 1'b1;
      flag_ones_q   <= 1'b0;
      flag_parity_q <= 1'b0;
    end else begin
      result_q      <= result_d;
      acc_q         <= acc_d;
      out_valid_q   <= out_valid_d;
      flag_zero_q   <= flag_zero_d;
      flag_ones_q   <= flag_ones_d;
      flag_parity_q <= flag_parity_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign flag_zero   = flag_zero_q;
  assign flag_ones   = flag_ones_q;
  assign flag_parity = flag_parity_q;

endmodule
`default_nettype wire

// File: tb/tb_bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitwise_logic_unit
// Brief    : Scoreboard bench for bitwise_logic_unit (WIDTH 32 and WIDTH 8)
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitwise_logic_unit;

  localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, XOR_ = 3'b010, NOR_ = 3'b011;
  localparam logic [2:0] NAND_ = 3'b100, XNOR_ = 3'b101, ANDN_ = 3'b110, PASS_ = 3'b111;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] data_a, data_b, result;
  logic [2:0]  op;
  logic [1:0]  mode;
  logic        flag_zero, flag_ones, flag_parity;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  data_a8, data_b8, result8;
  logic [2:0]  op8;
  logic [1:0]  mode8;
  logic        flag_zero8, flag_ones8, flag_parity8;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb_q[$];

  always #5 clock = ~clock;

  bitwise_logic_unit #(.WIDTH(32)) u_dut32 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .data_operandA(data_a), .data_operandB(data_b), .op(op), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_zero(flag_zero), .flag_ones(flag_ones), .flag_parity(flag_parity)
  );

  bitwise_logic_unit #(.WIDTH(8)) u_dut8 (
    .clock(clock), .resetn(resetn), .in_valid(in_valid8), .in_ready(in_ready8),
    .data_operandA(data_a8), .data_operandB(data_b8), .op(op8), .mode(mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .flag_zero(flag_zero8), .flag_ones(flag_ones8), .flag_parity(flag_parity8)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One cycle on the 32-bit unit. Inputs are driven after the falling edge and handshakes are
  // sampled 1 time unit later. A consume pops the scoreboard and an accept pushes exp.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] o, input logic [1:0] m, input logic ordy,
                      input logic [31:0] exp);
    logic [31:0] e;
    @(negedge clock);
    in_valid = v; data_a = a; data_b = b; op = o; mode = m; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("result", result, e);
        check_val("flag_zero", {31'd0, flag_zero}, {31'd0, e == 32'd0});
        check_val("flag_ones", {31'd0, flag_ones}, {31'd0, e == 32'hFFFF_FFFF});
        check_val("flag_parity", {31'd0, flag_parity}, {31'd0, ^e});
      end
    end
    if (in_valid && in_ready) sb_q.push_back(exp);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'd0, 32'd0, AND_, 2'b00, ordy, 32'd0);
  endtask

  initial begin
    logic [31:0] ops_exp [8];
    ops_exp = '{32'hF000_0034, 32'hFFF0_12FF, 32'h0FF0_12CB, 32'h000F_ED00,
                32'h0FFF_FFCB, 32'hF00F_ED34, 32'h00F0_1200, 32'hF0F0_1234};

    resetn = 1'b0;
    in_valid = 0; data_a = 0; data_b = 0; op = 0; mode = 0; out_ready = 0;
    in_valid8 = 0; data_a8 = 0; data_b8 = 0; op8 = 0; mode8 = 0; out_ready8 = 1;
    repeat (3) @(negedge clock);
    #1;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_result", result, 32'd0);
    check_val("rst_flag_zero", {31'd0, flag_zero}, 32'd1);
    check_val("rst_flag_ones", {31'd0, flag_ones}, 32'd0);
    check_val("rst_flag_parity", {31'd0, flag_parity}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #2 resetn = 1'b1;

    // Mid-stream reset: one beat is pending under backpressure
    step(1'b1, 32'h0000_00FF, 32'h0, OR_, 2'b10, 1'b0, 32'h0000_00FF);
    idle(1'b0);
    check_val("pend_out_valid", {31'd0, out_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    sb_q.delete();
    check_val("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("mrst_result", result, 32'd0);
    check_val("mrst_flag_zero", {31'd0, flag_zero}, 32'd1);
    check_val("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    #2 resetn = 1'b1;
    step(1'b1, 32'h0000_00F0, 32'h0, OR_, 2'b01, 1'b1, 32'h0000_00F0);
    idle(1'b1);

    // Every op, one beat per cycle
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'hF0F0_1234, 32'hFF00_00FF, 3'(i), 2'b00, 1'b1, ops_exp[i]);
    end
    idle(1'b1);

    // Back-to-back reduction through the accumulator
    step(1'b1, 32'h0000_0001, 32'h0000_0001, PASS_, 2'b10, 1'b1, 32'h0000_0001);
    step(1'b1, 32'h0000_0100, 32'h0, OR_, 2'b01, 1'b1, 32'h0000_0101);
    step(1'b1, 32'h8000_0000, 32'h0, OR_, 2'b01, 1'b1, 32'h8000_0101);
    step(1'b1, 32'h8000_0101, 32'h0, XOR_, 2'b01, 1'b1, 32'h0000_0000);
    idle(1'b1);

    // Backpressure for 3 cycles, then accept and consume on the same edge
    step(1'b1, 32'h1234_5678, 32'h0, OR_, 2'b00, 1'b0, 32'h1234_5678);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, AND_, 2'b00, 1'b0, 32'h0F0F_0000);
      check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("bp_result", result, 32'h1234_5678);
      check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    step(1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, AND_, 2'b00, 1'b1, 32'h0F0F_0000);
    idle(1'b0);
    check_val("bp_keep_valid", {31'd0, out_valid}, 32'd1);
    check_val("bp_new_result", result, 32'h0F0F_0000);
    idle(1'b1);

    // Flag corner cases
    step(1'b1, 32'h0, 32'h0, NOR_, 2'b00, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 32'h1, 32'h0, XOR_, 2'b00, 1'b1, 32'h0000_0001);
    step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NAND_, 2'b00, 1'b1, 32'h0);
    step(1'b1, 32'h0000_00FF, 32'h0000_000F, XNOR_, 2'b11, 1'b1, 32'hFFFF_FF0F);
    idle(1'b1);
    idle(1'b1);
    check_val("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("sb_empty", sb_q.size(), 32'd0);
    check_val("held_result", result, 32'hFFFF_FF0F);
    check_val("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // 8-bit unit: mode 11 must leave acc (zero since reset) untouched
    @(negedge clock);
    in_valid8 = 1; data_a8 = 8'hA5; data_b8 = 8'h0F; op8 = XOR_; mode8 = 2'b11;
    #1 check_val("w8_in_ready", {31'd0, in_ready8}, 32'd1);
    @(negedge clock);
    in_valid8 = 1; data_a8 = 8'h00; data_b8 = 8'hFF; op8 = OR_; mode8 = 2'b01;
    #1;
    check_val("w8_m11_result", {24'd0, result8}, 32'h0000_00AA);
    check_val("w8_m11_valid", {31'd0, out_valid8}, 32'd1);
    check_val("w8_m11_parity", {31'd0, flag_parity8}, 32'd0);
    check_val("w8_m11_ones", {31'd0, flag_ones8}, 32'd0);
    @(negedge clock);
    in_valid8 = 0;
    #1;
    check_val("w8_acc_result", {24'd0, result8}, 32'd0);
    check_val("w8_acc_zero", {31'd0, flag_zero8}, 32'd1);
    @(negedge clock);
    #1 check_val("w8_drained", {31'd0, out_valid8}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
